orv32_inst_encoder: RTL and testbench
=====================================

// Module: orv32_inst_encoder
// PURPOSE
// Builds 32-bit RV32IMA/Zicsr instruction words from field-level requests. Inverse of the core's decode path:
// the debug/test program-buffer injector sends opcode/funct/reg/imm fields and gets legal instruction words.
// Output words are queued for the fetch-injection port. Illegal requests are dropped and counted.
// PARAMETERS
// DEPTH  2  output FIFO entries; power of two, >=2
// CNT_W  8  width of saturating illegal-request counter
// PORTS
// clk          in   1      clock
// rst_n        in   1      async active-low reset
// flush        in   1      sync clear of FIFO (counter kept)
// req_valid    in   1      request valid
// req_ready    out  1      request accepted when valid&ready
// req_opc      in   5      major opcode, inst[6:2] encoding of libopcode
// req_funct3   in   3      funct3
// req_alt      in   1      inst[30] (SUB/SRA/SRAI)
// req_muldiv   in   1      OP with funct7=0000001 (RV32M)
// req_amo_f5   in   5      AMO funct5
// req_rd       in   5      rd
// req_rs1      in   5      rs1 (CSR*I: uimm)
// req_rs2      in   5      rs2 (SLLI/SRLI/SRAI: shamt)
// req_imm      in   32     full-value immediate; CSR addr in [11:0]; AMO {aq,rl} in [1:0]
// inst_valid   out  1      FIFO head valid
// inst_ready   in   1      consumer pops head when valid&ready
// inst         out  32     encoded word, inst[1:0]=2'b11
// err_illegal  out  1      1-cycle pulse, cycle after an illegal request is accepted
// err_cnt      out  CNT_W  saturating illegal count
// BEHAVIOUR
// - Reset: FIFO empty, inst_valid=0, inst=0, err_illegal=0, err_cnt=0, req_ready=1.
// - req_ready = !full. No pass-through when full. A push with a simultaneous pop when full is not taken.
// - Latency: accepted at cycle N, word visible at N+1 if FIFO was empty. Strict FIFO order.
// - Push and pop in the same cycle with 0<count<DEPTH: count unchanged.
// - flush has priority: it clears the FIFO and discards a same-cycle push. err_illegal still pulses for an illegal same-cycle request.
// - Format by opcode:
//   - U: LUI, AUIPC
//   - J: JAL
//   - I: JALR, LOAD, OP_IMM, FENCE, SYSTEM
//   - B: BRANCH
//   - S: STORE
//   - R: OP, AMO
// - OP funct7 = muldiv ? 7'b0000001 : {1'b0,req_alt,5'b0}.
// - OP_IMM shifts: imm[11:0] = {1'b0,req_alt,5'b0,req_rs2}.
// - AMO: inst[31:25] = {req_amo_f5, req_imm[1:0]}.
// - Illegal request (dropped, not pushed), any of:
//   - opcode not listed above; all FP opcodes are illegal
//   - I/S immediate: req_imm[31:11] not all equal
//   - B immediate: req_imm[31:12] not all equal, or imm[0]=1
//   - J immediate: req_imm[31:20] not all equal, or imm[0]=1
//   - U immediate: req_imm[11:0] != 0
//   - BRANCH funct3 010/011; LOAD funct3 011/110/111; STORE funct3 > 010; SYSTEM funct3 100; AMO funct3 != 010
//   - JALR funct3 != 0
//   - req_alt set outside ADD_SUB/SRL_SRA (OP) or SRLI_SRAI (OP_IMM)
//   - req_muldiv with req_alt, or req_muldiv with opcode != OP
// - err_cnt saturates at 2^CNT_W-1.
// - Async reset mid-operation empties the FIFO; in-flight requests are lost.
// STRUCTURE
// - Add to libopcode: typedef enum logic[2:0] {FMT_R,FMT_I,FMT_S,FMT_B,FMT_U,FMT_J} inst_fmt_e, and function fmt_of(opc).
// - Sub-module orv32_enc_fifo (DEPTH x 32, ptr+count, flush): storage for output words.
// - Encode and legality checks are combinational on the request; the result is registered into the FIFO.
// TESTING
// - ADDI x1,x0,5 (OP_IMM,f3=0,rd=1,imm=5) -> inst=0x00500093 at N+1.
// - LUI x5, imm=0x12345000 -> 0x123452B7; imm=0x12345001 -> err_illegal, err_cnt=1.
// - BEQ x1,x2, imm=0xFFFFFFFC -> 0xFE208EE3. SRA x3,x1,x2 (alt=1,f3=101) -> 0x4020D1B3.
// - JAL imm=0x00000101 (odd) -> dropped, err_illegal pulse, inst_valid stays 0.
// - inst_ready=0, 3 back-to-back ADDIs -> req_ready=0 after 2 accepted; release -> words popped in order.
// - flush with FIFO full plus a same-cycle push -> FIFO empty next cycle, req_ready=1; 256 illegals -> err_cnt=255.

Source files
------------

// File: rtl/orv32_inst_encoder_pkg.sv
// Opcode map, instruction formats and opcode helpers for the RV32IMA/Zicsr encoder.
package orv32_inst_encoder_pkg;

   typedef enum logic [4:0] {
      OPC_LOAD     = 5'b00000,
      OPC_MISC_MEM = 5'b00011,
      OPC_OP_IMM   = 5'b00100,
      OPC_AUIPC    = 5'b00101,
      OPC_STORE    = 5'b01000,
      OPC_AMO      = 5'b01011,
      OPC_OP       = 5'b01100,
      OPC_LUI      = 5'b01101,
      OPC_BRANCH   = 5'b11000,
      OPC_JALR     = 5'b11001,
      OPC_JAL      = 5'b11011,
      OPC_SYSTEM   = 5'b11100
   } opcode_e;

   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} inst_fmt_e;

   function automatic inst_fmt_e fmt_of(input logic [4:0] opc);
      case (opc)
         OPC_LUI, OPC_AUIPC:                                  return FMT_U;
         OPC_JAL:                                             return FMT_J;
         OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM,
         OPC_SYSTEM:                                          return FMT_I;
         OPC_BRANCH:                                          return FMT_B;
         OPC_STORE:                                           return FMT_S;
         default:                                             return FMT_R;
      endcase
   endfunction

   // FP and custom opcodes fall outside this list and are rejected.
   function automatic logic opc_known(input logic [4:0] opc);
      case (opc)
         OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_AMO,
         OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: return 1'b1;
         default:                                                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/orv32_enc_fifo.sv
// Small power-of-two word FIFO with synchronous flush; head reads as zero when empty.
module orv32_enc_fifo
   import orv32_inst_encoder_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic         full,
   output logic         valid,
   output logic [W-1:0] dout
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign full   = (r_count == (PW+1)'(DEPTH));
   assign valid  = (r_count != '0);
   assign w_push = push & ~full;
   assign w_pop  = pop & valid;
   assign dout   = valid ? r_mem[r_rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible once counted.
   always_ff @(posedge clk) begin
      if (w_push && !flush) r_mem[r_wr_ptr] <= din;
   end

endmodule

// File: rtl/orv32_inst_encoder.sv
// Field-level request to RV32IMA/Zicsr instruction word encoder with legality
// checking, output FIFO and saturating illegal-request counter.
module orv32_inst_encoder
   import orv32_inst_encoder_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [4:0]       req_opc,
   input  logic [2:0]       req_funct3,
   input  logic             req_alt,
   input  logic             req_muldiv,
   input  logic [4:0]       req_amo_f5,
   input  logic [4:0]       req_rd,
   input  logic [4:0]       req_rs1,
   input  logic [4:0]       req_rs2,
   input  logic [31:0]      req_imm,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [31:0]      inst,
   output logic             err_illegal,
   output logic [CNT_W-1:0] err_cnt
);
   inst_fmt_e        w_fmt;
   logic             w_is_shift;
   logic [11:0]      w_imm12;
   logic [6:0]       w_funct7;
   logic             w_sx_i;
   logic             w_sx_b;
   logic             w_sx_j;
   logic             w_alt_ok;
   logic             w_illegal;
   logic [31:0]      w_inst;
   logic             w_full;
   logic             w_accept;
   logic             r_err_illegal;
   logic [CNT_W-1:0] r_err_cnt;

   always_comb begin
      w_fmt      = fmt_of(req_opc);
      w_is_shift = (req_opc == OPC_OP_IMM) && (req_funct3[1:0] == 2'b01);
      w_imm12    = w_is_shift ? {1'b0, req_alt, 5'b0, req_rs2} : req_imm[11:0];
      w_funct7   = (req_opc == OPC_AMO) ? {req_amo_f5, req_imm[1:0]} :
                   req_muldiv           ? 7'b0000001 : {1'b0, req_alt, 5'b0};
      w_sx_i     = (&req_imm[31:11]) | ~(|req_imm[31:11]);
      w_sx_b     = (&req_imm[31:12]) | ~(|req_imm[31:12]);
      w_sx_j     = (&req_imm[31:20]) | ~(|req_imm[31:20]);
      w_alt_ok   = ((req_opc == OPC_OP) && (req_funct3 == 3'b000 || req_funct3 == 3'b101)) ||
                   ((req_opc == OPC_OP_IMM) && (req_funct3 == 3'b101));

      w_inst = {w_funct7, req_rs2, req_rs1, req_funct3, req_rd, req_opc, 2'b11};
      case (w_fmt)
         FMT_I: w_inst = {w_imm12, req_rs1, req_funct3, req_rd, req_opc, 2'b11};
         FMT_S: w_inst = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0],
                          req_opc, 2'b11};
         FMT_B: w_inst = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                          req_imm[4:1], req_imm[11], req_opc, 2'b11};
         FMT_U: w_inst = {req_imm[31:12], req_rd, req_opc, 2'b11};
         FMT_J: w_inst = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                          req_rd, req_opc, 2'b11};
         default: ;
      endcase

      w_illegal = ~opc_known(req_opc);
      if (req_muldiv && (req_alt || req_opc != OPC_OP)) w_illegal = 1'b1;
      if (req_alt && !w_alt_ok)                         w_illegal = 1'b1;
      // Shift immediates come from rs2/alt, so req_imm is not range-checked there.
      case (w_fmt)
         FMT_I:   if (!w_is_shift && !w_sx_i)   w_illegal = 1'b1;
         FMT_S:   if (!w_sx_i)                  w_illegal = 1'b1;
         FMT_B:   if (!w_sx_b || req_imm[0])    w_illegal = 1'b1;
         FMT_J:   if (!w_sx_j || req_imm[0])    w_illegal = 1'b1;
         FMT_U:   if (|req_imm[11:0])           w_illegal = 1'b1;
         default: ;
      endcase
      case (req_opc)
         OPC_BRANCH: if (req_funct3[2:1] == 2'b01)                      w_illegal = 1'b1;
         OPC_LOAD:   if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11) w_illegal = 1'b1;
         OPC_STORE:  if (req_funct3 > 3'b010)                           w_illegal = 1'b1;
         OPC_SYSTEM: if (req_funct3 == 3'b100)                          w_illegal = 1'b1;
         OPC_AMO:    if (req_funct3 != 3'b010)                          w_illegal = 1'b1;
         OPC_JALR:   if (req_funct3 != 3'b000)                          w_illegal = 1'b1;
         default: ;
      endcase
   end

   assign req_ready = ~w_full;
   assign w_accept  = req_valid & req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_illegal <= 1'b0;
         r_err_cnt     <= '0;
      end else begin
         r_err_illegal <= w_accept & w_illegal;
         if (w_accept && w_illegal && r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   assign err_illegal = r_err_illegal;
   assign err_cnt     = r_err_cnt;

   orv32_enc_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (w_accept & ~w_illegal),
      .din   (w_inst),
      .pop   (inst_ready),
      .full  (w_full),
      .valid (inst_valid),
      .dout  (inst)
   );

endmodule

// File: tb/tb_orv32_inst_encoder.sv
// Randomized and directed bench for orv32_inst_encoder against a queue-based reference model.
module tb_orv32_inst_encoder;
   localparam int DEPTH = 2;
   localparam int CNT_W = 8;

   localparam logic [4:0] M_LOAD = 5'b00000, M_FENCE = 5'b00011, M_OPIMM = 5'b00100,
                          M_AUIPC = 5'b00101, M_STORE = 5'b01000, M_AMO = 5'b01011,
                          M_OP = 5'b01100, M_LUI = 5'b01101, M_BRANCH = 5'b11000,
                          M_JALR = 5'b11001, M_JAL = 5'b11011, M_SYSTEM = 5'b11100;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [4:0]       req_opc = '0;
   logic [2:0]       req_funct3 = '0;
   logic             req_alt = 1'b0;
   logic             req_muldiv = 1'b0;
   logic [4:0]       req_amo_f5 = '0;
   logic [4:0]       req_rd = '0;
   logic [4:0]       req_rs1 = '0;
   logic [4:0]       req_rs2 = '0;
   logic [31:0]      req_imm = '0;
   logic             inst_valid;
   logic             inst_ready = 1'b1;
   logic [31:0]      inst;
   logic             err_illegal;
   logic [CNT_W-1:0] err_cnt;

   int n_vec  = 0;
   int n_fail = 0;

   logic [31:0] m_q[$];
   int          m_cnt = 0;
   bit          m_err = 0;

   always #5 clk = ~clk;

   orv32_inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
      .req_opc(req_opc), .req_funct3(req_funct3), .req_alt(req_alt), .req_muldiv(req_muldiv),
      .req_amo_f5(req_amo_f5), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .req_imm(req_imm), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .err_illegal(err_illegal), .err_cnt(err_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_illegal(input logic [4:0] opc, input logic [2:0] f3, input bit alt,
                                    input bit md, input logic [31:0] imm);
      int  si   = int'($signed(imm));
      bit  i_ok = (si >= -2048) && (si <= 2047);
      bit  b_ok = (si >= -4096) && (si <= 4095) && (imm % 2 == 0);
      bit  j_ok = (si >= -(1 << 20)) && (si < (1 << 20)) && (imm % 2 == 0);
      bit  sh   = (opc == M_OPIMM) && (f3 == 1 || f3 == 5);
      bit  ill  = 0;
      if (md && (alt || opc != M_OP)) ill = 1;
      if (alt && !((opc == M_OP && (f3 == 0 || f3 == 5)) || (opc == M_OPIMM && f3 == 5))) ill = 1;
      case (opc)
         M_LUI, M_AUIPC: if (imm % 4096 != 0) ill = 1;
         M_JAL:          if (!j_ok) ill = 1;
         M_JALR:         if (!i_ok || f3 != 0) ill = 1;
         M_LOAD:         if (!i_ok || f3 == 3 || f3 == 6 || f3 == 7) ill = 1;
         M_OPIMM:        if (!sh && !i_ok) ill = 1;
         M_FENCE:        if (!i_ok) ill = 1;
         M_SYSTEM:       if (!i_ok || f3 == 4) ill = 1;
         M_BRANCH:       if (!b_ok || f3 == 2 || f3 == 3) ill = 1;
         M_STORE:        if (!i_ok || f3 > 2) ill = 1;
         M_OP:           ;
         M_AMO:          if (f3 != 2) ill = 1;
         default:        ill = 1;
      endcase
      return ill;
   endfunction

   function automatic logic [31:0] m_enc(input logic [4:0] opc, input logic [2:0] f3,
                                         input bit alt, input bit md, input logic [4:0] f5,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [31:0] imm);
      logic [31:0] base = 32'(opc) * 4 + 3;
      logic [31:0] regs = (32'(rs2) << 20) + (32'(rs1) << 15) + (32'(f3) << 12);
      logic [31:0] f7;
      case (opc)
         M_LUI, M_AUIPC: return imm + (32'(rd) << 7) + base;
         M_JAL: return (((imm >> 20) & 1) << 31) + (((imm >> 1) & 32'h3ff) << 21) +
                       (((imm >> 11) & 1) << 20) + (((imm >> 12) & 32'hff) << 12) +
                       (32'(rd) << 7) + base;
         M_BRANCH: return (((imm >> 12) & 1) << 31) + (((imm >> 5) & 63) << 25) + regs +
                          (((imm >> 1) & 15) << 8) + (((imm >> 11) & 1) << 7) + base;
         M_STORE: return (((imm >> 5) & 127) << 25) + regs + ((imm & 31) << 7) + base;
         M_OP, M_AMO: begin
            if (opc == M_AMO) f7 = 32'(f5) * 4 + (imm & 3);
            else if (md)      f7 = 1;
            else              f7 = alt ? 32 : 0;
            return (f7 << 25) + regs + (32'(rd) << 7) + base;
         end
         default: begin
            if (opc == M_OPIMM && (f3 == 1 || f3 == 5))
               return ((alt ? 32'd1024 : 32'd0) + 32'(rs2)) * (1 << 20) + (32'(rs1) << 15) +
                      (32'(f3) << 12) + (32'(rd) << 7) + base;
            return ((imm & 32'hfff) << 20) + (32'(rs1) << 15) + (32'(f3) << 12) +
                   (32'(rd) << 7) + base;
         end
      endcase
   endfunction

   // Apply current inputs for one clock, advance the model, then compare all outputs.
   task automatic step();
      bit ready = (m_q.size() < DEPTH);
      bit acc   = req_valid && ready;
      bit ill   = m_illegal(req_opc, req_funct3, req_alt, req_muldiv, req_imm);
      logic [31:0] w = m_enc(req_opc, req_funct3, req_alt, req_muldiv, req_amo_f5,
                             req_rd, req_rs1, req_rs2, req_imm);
      bit pop = (m_q.size() > 0) && inst_ready;
      if (flush) m_q.delete();
      else begin
         if (pop) void'(m_q.pop_front());
         if (acc && !ill) m_q.push_back(w);
      end
      m_err = acc && ill;
      if (acc && ill && m_cnt < 255) m_cnt++;
      @(posedge clk);
      @(negedge clk);
      chk("inst_valid", 32'(inst_valid), 32'(m_q.size() > 0));
      chk("inst", inst, (m_q.size() > 0) ? m_q[0] : 32'h0);
      chk("req_ready", 32'(req_ready), 32'(m_q.size() < DEPTH));
      chk("err_illegal", 32'(err_illegal), 32'(m_err));
      chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
   endtask

   task automatic set_req(input logic [4:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                          input bit alt);
      req_valid = 1; req_opc = opc; req_funct3 = f3; req_rd = rd; req_rs1 = rs1;
      req_rs2 = rs2; req_imm = imm; req_alt = alt; req_muldiv = 0; req_amo_f5 = 0;
   endtask

   task automatic rand_req();
      logic [4:0] opcs [12] = '{M_LOAD, M_FENCE, M_OPIMM, M_AUIPC, M_STORE, M_AMO,
                                M_OP, M_LUI, M_BRANCH, M_JALR, M_JAL, M_SYSTEM};
      req_valid  = ($urandom_range(0, 3) != 0);
      req_opc    = ($urandom_range(0, 9) == 0) ? 5'($urandom) : opcs[$urandom_range(0, 11)];
      req_funct3 = 3'($urandom);
      req_alt    = ($urandom_range(0, 3) == 0);
      req_muldiv = ($urandom_range(0, 7) == 0);
      req_amo_f5 = 5'($urandom);
      req_rd     = 5'($urandom);
      req_rs1    = 5'($urandom);
      req_rs2    = 5'($urandom);
      case ($urandom_range(0, 3))
         0:       req_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
         1:       req_imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
         2:       req_imm = $urandom;
         default: req_imm = $urandom & 32'hfffff000;
      endcase
      inst_ready = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 19) == 0);
   endtask

   initial begin
      #23;
      chk("rst_inst_valid", 32'(inst_valid), 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_req_ready", 32'(req_ready), 32'h1);
      chk("rst_err_cnt", 32'(err_cnt), 32'h0);
      @(negedge clk);
      rst_n = 1;

      set_req(M_OPIMM, 0, 1, 0, 0, 32'd5, 0); step();
      chk("addi", inst, 32'h00500093);
      set_req(M_LUI, 0, 5, 0, 0, 32'h12345000, 0); step();
      chk("lui", inst, 32'h123452B7);
      set_req(M_LUI, 0, 5, 0, 0, 32'h12345001, 0); step();
      chk("lui_bad_pulse", 32'(err_illegal), 32'h1);
      chk("lui_bad_cnt", 32'(err_cnt), 32'h1);
      set_req(M_BRANCH, 0, 0, 1, 2, 32'hFFFFFFFC, 0); step();
      chk("beq", inst, 32'hFE208EE3);
      set_req(M_OP, 3'b101, 3, 1, 2, 32'h0, 1); step();
      chk("sra", inst, 32'h4020D1B3);
      set_req(M_JAL, 0, 1, 0, 0, 32'h00000101, 0); step();
      chk("jal_odd_pulse", 32'(err_illegal), 32'h1);
      chk("jal_odd_valid", 32'(inst_valid), 32'h0);

      inst_ready = 0;
      for (int i = 1; i <= 3; i++) begin
         set_req(M_OPIMM, 0, 1, 0, 0, 32'(i), 0); step();
      end
      chk("bp_ready_low", 32'(req_ready), 32'h0);
      req_valid = 0; inst_ready = 1; step();
      step();

      inst_ready = 0;
      for (int i = 0; i < 2; i++) begin
         set_req(M_OPIMM, 0, 2, 0, 0, 32'(i + 7), 0); step();
      end
      flush = 1; set_req(M_OPIMM, 0, 3, 0, 0, 32'd9, 0); step();
      flush = 0; req_valid = 0;
      chk("flush_empty", 32'(inst_valid), 32'h0);
      chk("flush_ready", 32'(req_ready), 32'h1);
      inst_ready = 1;

      for (int i = 0; i < 3000; i++) begin
         rand_req();
         step();
      end
      flush = 0;

      inst_ready = 1;
      for (int i = 0; i < 300; i++) begin
         set_req(5'b00001, 0, 0, 0, 0, 32'h0, 0); step();
      end
      chk("err_cnt_sat", 32'(err_cnt), 32'd255);

      inst_ready = 0;
      set_req(M_OPIMM, 0, 4, 0, 0, 32'd1, 0); step();
      req_valid = 0;
      rst_n = 0;
      m_q.delete(); m_cnt = 0; m_err = 0;
      #2;
      chk("midrst_valid", 32'(inst_valid), 32'h0);
      chk("midrst_cnt", 32'(err_cnt), 32'h0);
      rst_n = 1;
      @(negedge clk);
      inst_ready = 1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
